// File: rtl/seq_divider_16_8_pkg.sv
// Shared widths, state encoding and iteration count for the 16/8 restoring divider.
// Optional feature macro: DIVIDER_EARLY_TERM_EN (see seq_divider_16_8.sv).
package seq_divider_16_8_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER_COUNT = DIVIDEND_W;
  localparam int CNT_W      = $clog2(ITER_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_divider_16_8_if.sv
// Request/response bundle between a controller (master) and the divider (slave).
interface seq_divider_16_8_if;
  import seq_divider_16_8_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  done_flag;
  logic                  busy;
  logic                  div_by_zero;
  logic [2:0]            state_out;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done_flag, busy, div_by_zero, state_out
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done_flag, busy, div_by_zero, state_out
  );

endinterface

// File: rtl/seq_divider_16_8_div_restore_step.sv
// One restoring-division step: shift the next dividend bit into R, subtract D if it fits.
module div_restore_step
  import seq_divider_16_8_pkg::*;
(
  input  logic [DIVISOR_W:0]   r_i,
  input  logic                 q_msb_i,
  input  logic [DIVISOR_W-1:0] d_i,
  output logic [DIVISOR_W:0]   r_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W:0] rs;
  logic [DIVISOR_W:0] dz;

  // R stays below D, so dropping R's top bit before the shift loses nothing.
  assign rs = {r_i[DIVISOR_W-1:0], q_msb_i};
  assign dz = {1'b0, d_i};

  always_comb begin
    r_o     = rs;
    q_bit_o = 1'b0;
    if (rs >= dz) begin
      r_o     = rs - dz;
      q_bit_o = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider_16_8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_EARLY_TERM_EN to short-circuit dividend < divisor straight to DONE.
module seq_divider_16_8
  import seq_divider_16_8_pkg::*;
(
  input  logic              clk,
  input  logic              reset_a,
  seq_divider_16_8_if.slave bus
);

  localparam int MSB = DIVIDEND_W - 1;

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVISOR_W-1:0]  d_q, d_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;

  logic [DIVISOR_W:0]    step_r;
  logic                  step_qb;

  div_restore_step u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[MSB]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_qb)
  );

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: begin
        q_d   = bus.dividend;
        d_d   = bus.divisor;
        r_d   = '0;
        cnt_d = '0;
        // Error results are published on entry so they are stable with done_flag.
        if (bus.divisor == '0) begin
          state_d = S_ERR;
          quot_d  = '1;
          rem_d   = bus.dividend[DIVISOR_W-1:0];
        end
`ifdef DIVIDER_EARLY_TERM_EN
        else if (bus.dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, bus.divisor}) begin
          state_d = S_DONE;
          quot_d  = '0;
          rem_d   = bus.dividend[DIVISOR_W-1:0];
        end
`endif
        else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        q_d   = {q_q[MSB-1:0], step_qb};
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          quot_d  = {q_q[MSB-1:0], step_qb};
          rem_d   = step_r[DIVISOR_W-1:0];
        end
      end
      S_DONE, S_ERR: if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.done_flag   = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.busy        = (state_q == S_LOAD) || (state_q == S_ITER);
  assign bus.div_by_zero = (state_q == S_ERR);
  assign bus.state_out   = state_q;

endmodule

// File: tb/tb_seq_divider_16_8.sv
// Scoreboard bench for seq_divider_16_8: driver pushes expected results, monitor checks on done_flag rise.
module tb_seq_divider_16_8;
  import seq_divider_16_8_pkg::*;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
    int          t0;
  } exp_t;

`ifdef DIVIDER_EARLY_TERM_EN
  localparam int SMALL_LAT = 2;
`else
  localparam int SMALL_LAT = 18;
`endif

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  seq_divider_16_8_if bus();

  seq_divider_16_8 dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every completed operation against the oldest queued expectation.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_a && bus.done_flag && !done_prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done_flag=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient",    32'(bus.quotient),    32'(e.q));
          chk("remainder",   32'(bus.remainder),   32'(e.r));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          chk("latency",     32'(cyc - e.t0),      32'(e.lat));
        end
      end
      done_prev = bus.done_flag;
    end
  end

  // mode 0: plain, 1: trace state_out each cycle, 2: disturb operands/start mid-ITER
  task automatic run(input logic [15:0] dvd, input logic [7:0] dvs, input logic [15:0] eq,
                     input logic [7:0] er, input logic edbz, input int elat, input int mode);
    int n;
    exp_t e;
    @(negedge clk);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat; e.t0 = cyc;
    sb.push_back(e);
    n = 0;
    while (!bus.done_flag && n < 40) begin
      @(negedge clk);
      n++;
      if (mode == 1) chk("state_seq", 32'(bus.state_out), (n == 1) ? 32'd1 : (n <= 17) ? 32'd2 : 32'd3);
      if (mode == 2 && n == 5) begin
        bus.dividend = ~dvd;
        bus.divisor  = 8'h00;
        bus.start    = 1'b0;
      end
      if (mode == 2 && n == 6) bus.start = 1'b1;
    end
    chk("done_seen", 32'(bus.done_flag), 32'd1);
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("hold_while_start", 32'(bus.state_out), edbz ? 32'd4 : 32'd3);
    bus.start = 1'b0;
    @(negedge clk);
    chk("back_to_idle", 32'(bus.state_out), 32'd0);
    chk("dbz_cleared", 32'(bus.div_by_zero), 32'd0);
    chk("quot_kept_idle", 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_state",    32'(bus.state_out),   32'd0);
    chk("rst_quotient", 32'(bus.quotient),    32'd0);
    chk("rst_remainder",32'(bus.remainder),   32'd0);
    chk("rst_flags",    32'({bus.done_flag, bus.busy, bus.div_by_zero}), 32'd0);
    reset_a = 1'b0;

    run(16'd100,   8'd7,    16'd14,    8'd2,    1'b0, 18, 1);
    run(16'h448E,  8'h5A,   16'h00C3,  8'h00,   1'b0, 18, 0);
    run(16'd65535, 8'd255,  16'd257,   8'd0,    1'b0, 18, 0);
    run(16'hFFFF,  8'd1,    16'hFFFF,  8'd0,    1'b0, 18, 0);
    run(16'd54321, 8'd123,  16'd441,   8'd78,   1'b0, 18, 0);
    run(16'h1234,  8'd0,    16'hFFFF,  8'h34,   1'b1, 2,  0);
    run(16'd5,     8'd9,    16'd0,     8'd5,    1'b0, SMALL_LAT, 0);
    run(16'd0,     8'd5,    16'd0,     8'd0,    1'b0, SMALL_LAT, 0);
    run(16'd1000,  8'd10,   16'd100,   8'd0,    1'b0, 18, 2);

    // Abort a run in its 8th ITER cycle; nothing is queued for it.
    @(negedge clk);
    bus.dividend = 16'd300;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    repeat (9) @(negedge clk);
    chk("pre_abort_iter", 32'(bus.state_out), 32'd2);
    reset_a   = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("abort_state",    32'(bus.state_out), 32'd0);
    chk("abort_quotient", 32'(bus.quotient),  32'd0);
    chk("abort_remainder",32'(bus.remainder), 32'd0);
    chk("abort_flags",    32'({bus.done_flag, bus.busy, bus.div_by_zero}), 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    run(16'd200,   8'd3,    16'd66,    8'd2,    1'b0, 18, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
